// File: rtl/xy_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | xy_sched_pkg                                                         |
// | Source IDs, FSM state type and coordinate type for the XY scheduler. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package xy_sched_pkg;

  localparam logic [1:0] BORDER = 2'd0;
  localparam logic [1:0] PLATE  = 2'd1;
  localparam logic [1:0] BALL   = 2'd2;
  localparam logic [1:0] NONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  typedef logic [7:0] coord_t;

  // Down-counters run from N-1 to 0, so a request for 0 cycles behaves like 1.
  function automatic logic [7:0] count_load(input int unsigned cycles);
    return (cycles == 0) ? 8'd0 : 8'(cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xy_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | xy_rr_arbiter                                                        |
// | 3-way rotating-priority arbiter; search starts after the last grant. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module xy_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);

  logic [2:0] last_gnt;

  always_comb begin
    grant = 3'b000;
    case (last_gnt)
      3'b001: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      3'b010: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  // Starting at "ball" makes border the first source served after reset.
  always_ff @(posedge clk) begin
    if (reset)
      last_gnt <= 3'b100;
    else if (advance && (|grant))
      last_gnt <= grant;
  end

endmodule
`default_nettype wire

// File: rtl/xy_draw_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | xy_draw_scheduler                                                    |
// | Time-multiplexes border/plate/ball points onto one XY DAC.           |
// | Option macro: XY_SCHED_SETTLE_BLANK_EN (blanked settle after a jump) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module xy_draw_scheduler
  import xy_sched_pkg::*;
#(
  parameter int unsigned DWELL_BORDER = 1,
  parameter int unsigned DWELL_PLATE  = 2,
  parameter int unsigned DWELL_BALL   = 4,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_border,
  input  logic       req_plate,
  input  logic       req_ball,
  input  logic [7:0] x_border,
  input  logic [7:0] y_border,
  input  logic [7:0] x_plate,
  input  logic [7:0] y_plate,
  input  logic [7:0] x_ball,
  input  logic [7:0] y_ball,
  output logic       ack_border,
  output logic       ack_plate,
  output logic       ack_ball,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       blank,
  output logic [1:0] src
);

  localparam logic [7:0] DW_LD_BORDER = count_load(DWELL_BORDER);
  localparam logic [7:0] DW_LD_PLATE  = count_load(DWELL_PLATE);
  localparam logic [7:0] DW_LD_BALL   = count_load(DWELL_BALL);
  localparam logic [7:0] SETTLE_LD    = count_load(SETTLE_CYC);

  state_t     state, state_nxt;
  logic [2:0] gnt;
  logic       grant_fire;
  logic [1:0] gnt_id;
  coord_t     gnt_x, gnt_y;
  logic [7:0] gnt_dwell;
  logic [7:0] settle_cnt, dwell_cnt;

  xy_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req_ball, req_plate, req_border}),
    .advance (grant_fire),
    .grant   (gnt)
  );

  assign grant_fire = (state == IDLE) && !reset && (|gnt);

  always_comb begin
    gnt_id    = BALL;
    gnt_x     = x_ball;
    gnt_y     = y_ball;
    gnt_dwell = DW_LD_BALL;
    if (gnt[0]) begin
      gnt_id    = BORDER;
      gnt_x     = x_border;
      gnt_y     = y_border;
      gnt_dwell = DW_LD_BORDER;
    end else if (gnt[1]) begin
      gnt_id    = PLATE;
      gnt_x     = x_plate;
      gnt_y     = y_plate;
      gnt_dwell = DW_LD_PLATE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    blank      = 1'b1;
    ack_border = grant_fire & gnt[0];
    ack_plate  = grant_fire & gnt[1];
    ack_ball   = grant_fire & gnt[2];
    case (state)
      IDLE: begin
        if (grant_fire) begin
`ifdef XY_SCHED_SETTLE_BLANK_EN
          state_nxt = (SETTLE_CYC == 0) ? DWELL : SETTLE;
`else
          state_nxt = DWELL;
`endif
        end
      end
      SETTLE: begin
        if (settle_cnt == 8'd0)
          state_nxt = DWELL;
      end
      DWELL: begin
        blank = 1'b0;
        if (dwell_cnt == 8'd0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // src returns to NONE on the same edge that takes the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= 8'd0;
      y          <= 8'd0;
      src        <= NONE;
      settle_cnt <= 8'd0;
      dwell_cnt  <= 8'd0;
    end else if (grant_fire) begin
      x          <= gnt_x;
      y          <= gnt_y;
      src        <= gnt_id;
      settle_cnt <= SETTLE_LD;
      dwell_cnt  <= gnt_dwell;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt != 8'd0)
            settle_cnt <= settle_cnt - 8'd1;
        end
        DWELL: begin
          if (dwell_cnt == 8'd0)
            src <= NONE;
          else
            dwell_cnt <= dwell_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xy_draw_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xy_draw_scheduler                                                 |
// | Directed scenarios plus random traffic against a timeline model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_xy_draw_scheduler;

`ifdef XY_SCHED_SETTLE_BLANK_EN
  localparam int S_EXP = 2;
`else
  localparam int S_EXP = 0;
`endif

  logic       clk;
  logic       reset;
  logic       req_border, req_plate, req_ball;
  logic [7:0] x_border, y_border, x_plate, y_plate, x_ball, y_ball;
  logic       ack_border, ack_plate, ack_ball;
  logic [7:0] x, y;
  logic       blank;
  logic [1:0] src;

  logic       req2_border;
  logic [7:0] x2_border, y2_border;
  logic       zero_req;
  logic [7:0] zero_coord;
  logic       ack2_border, ack2_plate, ack2_ball;
  logic [7:0] x2, y2;
  logic       blank2;
  logic [1:0] src2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] obs, obs2;
  assign obs  = {ack_ball, ack_plate, ack_border, x, y, blank, src};
  assign obs2 = {ack2_ball, ack2_plate, ack2_border, x2, y2, blank2, src2};

  xy_draw_scheduler dut (
    .clk(clk), .reset(reset),
    .req_border(req_border), .req_plate(req_plate), .req_ball(req_ball),
    .x_border(x_border), .y_border(y_border),
    .x_plate(x_plate), .y_plate(y_plate),
    .x_ball(x_ball), .y_ball(y_ball),
    .ack_border(ack_border), .ack_plate(ack_plate), .ack_ball(ack_ball),
    .x(x), .y(y), .blank(blank), .src(src)
  );

  xy_draw_scheduler #(.DWELL_BORDER(0), .SETTLE_CYC(0)) dut2 (
    .clk(clk), .reset(reset),
    .req_border(req2_border), .req_plate(zero_req), .req_ball(zero_req),
    .x_border(x2_border), .y_border(y2_border),
    .x_plate(zero_coord), .y_plate(zero_coord),
    .x_ball(zero_coord), .y_ball(zero_coord),
    .ack_border(ack2_border), .ack_plate(ack2_plate), .ack_ball(ack2_ball),
    .x(x2), .y(y2), .blank(blank2), .src(src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] pack(input logic [2:0] a, input logic [7:0] ex,
                                       input logic [7:0] ey, input logic b,
                                       input logic [1:0] s);
    return {a, ex, ey, b, s};
  endfunction

  // Next source after 'last' in the cyclic order border, plate, ball; 3 if none.
  function automatic int pick(input logic [2:0] rq, input int last);
    for (int i = 1; i <= 3; i++) begin
      if (rq[(last + i) % 3]) return (last + i) % 3;
    end
    return 3;
  endfunction

  function automatic int dwell_of(input int s);
    case (s)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Invariants watched on every cycle once the design is out of its X state.
  logic [7:0] px, py;
  logic       pa, pr;
  bit         mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (!$onehot0({ack_border, ack_plate, ack_ball})) begin
        n_bad++;
        $display("FAIL ack_onehot: got %b required at most one set", {ack_ball, ack_plate, ack_border});
      end
      n_cmp++;
      if ((x !== px || y !== py) && !pa && !pr) begin
        n_bad++;
        $display("FAIL xy_stable: got %h/%h required %h/%h (no ack or reset before)", x, y, px, py);
      end
    end
    px = x;
    py = y;
    pa = ack_border | ack_plate | ack_ball;
    pr = reset;
  end

  task automatic clear_reqs();
    req_border = 1'b0; req_plate = 1'b0; req_ball = 1'b0; req2_border = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    clear_reqs();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_border = 1'b1; req_plate = 1'b1; req_ball = 1'b1; req2_border = 1'b1;
    x_border = 8'h12; y_border = 8'h34; x2_border = 8'h56; y2_border = 8'h78;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (obs !== pack(3'b000, 8'h00, 8'h00, 1'b1, 2'd3)) begin
      n_bad++;
      $display("FAIL reset_state: got %h required %h", obs, pack(3'b000, 8'h00, 8'h00, 1'b1, 2'd3));
    end
    n_cmp++;
    if (obs2 !== pack(3'b000, 8'h00, 8'h00, 1'b1, 2'd3)) begin
      n_bad++;
      $display("FAIL reset_state_dut2: got %h required %h", obs2, pack(3'b000, 8'h00, 8'h00, 1'b1, 2'd3));
    end
  endtask

  task automatic test_single_ball();
    logic [21:0] e;
    reset_dut();
    req_ball = 1'b1; x_ball = 8'h40; y_ball = 8'h80;
    for (int c = 1; c <= 7 + S_EXP; c++) begin
      if (c > 1) begin @(posedge clk); #1; req_ball = 1'b0; end
      @(negedge clk);
      if (c == 1)              e = pack(3'b100, 8'h00, 8'h00, 1'b1, 2'd3);
      else if (c < 2 + S_EXP)  e = pack(3'b000, 8'h40, 8'h80, 1'b1, 2'd2);
      else if (c < 6 + S_EXP)  e = pack(3'b000, 8'h40, 8'h80, 1'b0, 2'd2);
      else                     e = pack(3'b000, 8'h40, 8'h80, 1'b1, 2'd3);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL single_ball c=%0d: got %h required %h", c, obs, e);
      end
    end
  endtask

  task automatic test_all_three();
    int t[$];
    int who[$];
    int e_t[4];
    int e_id[4];
    reset_dut();
    req_border = 1'b1; req_plate = 1'b1; req_ball = 1'b1;
    x_border = 8'h01; y_border = 8'h02; x_plate = 8'h03; y_plate = 8'h04;
    x_ball = 8'h05; y_ball = 8'h06;
    for (int c = 1; c <= 40 && t.size() < 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (ack_border) begin t.push_back(c); who.push_back(0); end
      if (ack_plate)  begin t.push_back(c); who.push_back(1); end
      if (ack_ball)   begin t.push_back(c); who.push_back(2); end
    end
    e_t[0] = 1;
    e_t[1] = e_t[0] + 1 + S_EXP + 1;
    e_t[2] = e_t[1] + 1 + S_EXP + 2;
    e_t[3] = e_t[2] + 1 + S_EXP + 4;
    e_id = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (t.size() <= i) begin
        n_bad++;
        $display("FAIL all_three grant%0d: got no ack within 40 cycles required src %0d at cycle %0d", i, e_id[i], e_t[i]);
      end else if (t[i] != e_t[i] || who[i] != e_id[i]) begin
        n_bad++;
        $display("FAIL all_three grant%0d: got src %0d at cycle %0d required src %0d at cycle %0d",
                 i, who[i], t[i], e_id[i], e_t[i]);
      end
    end
    clear_reqs();
  endtask

  task automatic test_plate();
    logic [21:0] e;
    reset_dut();
    req_plate = 1'b1; x_plate = 8'hC3; y_plate = 8'h3C;
    for (int c = 1; c <= 4 + S_EXP; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c == 1)               e = pack(3'b010, 8'h00, 8'h00, 1'b1, 2'd3);
      else if (c < 2 + S_EXP)   e = pack(3'b000, 8'hC3, 8'h3C, 1'b1, 2'd1);
      else if (c < 4 + S_EXP)   e = pack(3'b000, 8'hC3, 8'h3C, 1'b0, 2'd1);
      else                      e = pack(3'b010, 8'hC3, 8'h3C, 1'b1, 2'd3);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL plate_repeat c=%0d: got %h required %h", c, obs, e);
      end
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid_dwell();
    reset_dut();
    req_ball = 1'b1; x_ball = 8'h55; y_ball = 8'hAA;
    for (int c = 1; c <= 3 + S_EXP; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        req_ball = 1'b0;
        if (c == 3 + S_EXP) reset = 1'b1;
      end
      @(negedge clk);
      if (c == 3 + S_EXP) begin
        n_cmp++;
        if ({blank, src} !== {1'b0, 2'd2}) begin
          n_bad++;
          $display("FAIL mid_dwell_pre: got blank=%b src=%0d required blank=0 src=2", blank, src);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req_border = 1'b1; req_ball = 1'b1;
    x_border = 8'h77; y_border = 8'h66;
    @(negedge clk);
    n_cmp++;
    if (obs !== pack(3'b001, 8'h00, 8'h00, 1'b1, 2'd3)) begin
      n_bad++;
      $display("FAIL mid_dwell_reset: got %h required %h", obs, pack(3'b001, 8'h00, 8'h00, 1'b1, 2'd3));
    end
    clear_reqs();
  endtask

  task automatic test_dwell_zero();
    logic [21:0] e;
    reset_dut();
    req2_border = 1'b1; x2_border = 8'h11; y2_border = 8'h22;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c == 1)          e = pack(3'b001, 8'h00, 8'h00, 1'b1, 2'd3);
      else if (c % 2 == 1) e = pack(3'b001, 8'h11, 8'h22, 1'b1, 2'd3);
      else                 e = pack(3'b000, 8'h11, 8'h22, 1'b0, 2'd0);
      n_cmp++;
      if (obs2 !== e) begin
        n_bad++;
        $display("FAIL dwell_zero c=%0d: got %h required %h", c, obs2, e);
      end
    end
    clear_reqs();
  endtask

  task automatic test_random();
    logic [2:0]  rq, eack, last_ack;
    logic [7:0]  cx[3], cy[3];
    logic [7:0]  m_x, m_y;
    logic [1:0]  m_src;
    logic        eb;
    logic [21:0] e;
    int          m_k, m_total, m_last, g;
    reset_dut();
    m_k = 0; m_total = 0; m_x = 8'h00; m_y = 8'h00; m_src = 2'd3; m_last = 2;
    rq = 3'b000; last_ack = 3'b000;
    for (int s = 0; s < 3; s++) begin cx[s] = 8'h00; cy[s] = 8'h00; end
    for (int n = 0; n < 800; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      reset = ($urandom_range(0, 149) == 0);
      for (int s = 0; s < 3; s++) begin
        if (rq[s]) begin
          if (last_ack[s]) begin
            if ($urandom_range(0, 1) == 0) rq[s] = 1'b0;
            else begin cx[s] = 8'($urandom); cy[s] = 8'($urandom); end
          end else if ($urandom_range(0, 15) == 0) begin
            rq[s] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rq[s] = 1'b1; cx[s] = 8'($urandom); cy[s] = 8'($urandom);
        end
      end
      {req_ball, req_plate, req_border} = rq;
      x_border = cx[0]; y_border = cy[0];
      x_plate  = cx[1]; y_plate  = cy[1];
      x_ball   = cx[2]; y_ball   = cy[2];
      @(negedge clk);
      g    = (m_k == 0 && !reset) ? pick(rq, m_last) : 3;
      eack = (g == 3) ? 3'b000 : (3'b001 << g);
      eb   = (m_k == 0) ? 1'b1 : (m_k <= S_EXP);
      e    = pack(eack, m_x, m_y, eb, m_src);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL random n=%0d: got %h required %h", n, obs, e);
      end
      last_ack = eack;
      if (reset) begin
        m_k = 0; m_x = 8'h00; m_y = 8'h00; m_src = 2'd3; m_last = 2;
      end else if (g != 3) begin
        m_x = cx[g]; m_y = cy[g]; m_src = 2'(g); m_last = g;
        m_k = 1; m_total = S_EXP + dwell_of(g);
      end else if (m_k != 0) begin
        if (m_k == m_total) begin m_k = 0; m_src = 2'd3; end
        else m_k++;
      end
    end
    reset = 1'b0;
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    zero_req = 1'b0; zero_coord = 8'h00;
    x_border = 8'h00; y_border = 8'h00; x_plate = 8'h00; y_plate = 8'h00;
    x_ball = 8'h00; y_ball = 8'h00; x2_border = 8'h00; y2_border = 8'h00;
    test_reset();
    mon_en = 1'b1;
    test_single_ball();
    test_all_three();
    test_plate();
    test_reset_mid_dwell();
    test_dwell_zero();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
